// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a 1W/1R data RAM
// Define RAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed port-0 priority.
`timescale 1ns/1ps
module ram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  REQ_0,
   input  logic                  REQ_1,
   input  logic                  WE_0,
   input  logic                  WE_1,
   input  logic [ADDR_WIDTH-1:0] ADDR_0,
   input  logic [ADDR_WIDTH-1:0] ADDR_1,
   input  logic [DATA_WIDTH-1:0] WDATA_0,
   input  logic [DATA_WIDTH-1:0] WDATA_1,
   output logic                  GNT_0,
   output logic                  GNT_1,
   output logic                  RVALID_0,
   output logic                  RVALID_1,
   output logic [DATA_WIDTH-1:0] RDATA_0,
   output logic [DATA_WIDTH-1:0] RDATA_1,
   output logic                  RAM_ENABLE_W,
   output logic [ADDR_WIDTH-1:0] RAM_ADDR_W,
   output logic [DATA_WIDTH-1:0] RAM_Q_W,
   output logic [ADDR_WIDTH-1:0] RAM_ADDR_R,
   input  logic [DATA_WIDTH-1:0] RAM_Q_R
);

   logic                  b_valid;
   logic                  b_port;
   logic                  b_we;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  accept;

`ifndef RAM_ARB_FIXED_PRIO_EN
   // last = port granted most recently; the other port wins the next tie
   logic last;
`endif

   always_comb begin
      GNT_0 = 1'b0;
      GNT_1 = 1'b0;
      if (!RESET) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         GNT_0 = REQ_0;
         GNT_1 = REQ_1 && !REQ_0;
`else
         if (REQ_0 && REQ_1) begin
            GNT_0 = last;
            GNT_1 = !last;
         end else begin
            GNT_0 = REQ_0;
            GNT_1 = REQ_1;
         end
`endif
      end
   end

   assign accept = GNT_0 || GNT_1;

   // Stage B drives the RAM straight from the command register
   assign RAM_ENABLE_W = b_valid && b_we;
   assign RAM_ADDR_W   = b_addr;
   assign RAM_ADDR_R   = b_addr;
   assign RAM_Q_W      = b_wdata;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         b_valid <= 1'b0;
         b_port  <= 1'b0;
         b_we    <= 1'b0;
         b_addr  <= '0;
         b_wdata <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
         last    <= 1'b1;
`endif
      end else begin
         b_valid <= accept;
         if (accept) begin
            b_port  <= GNT_1;
            b_we    <= GNT_1 ? WE_1 : WE_0;
            b_addr  <= GNT_1 ? ADDR_1 : ADDR_0;
            b_wdata <= GNT_1 ? WDATA_1 : WDATA_0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last    <= GNT_1;
`endif
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RVALID_0 <= 1'b0;
         RVALID_1 <= 1'b0;
         RDATA_0  <= '0;
         RDATA_1  <= '0;
      end else begin
         RVALID_0 <= b_valid && !b_we && !b_port;
         RVALID_1 <= b_valid && !b_we && b_port;
         if (b_valid && !b_we && !b_port) begin
            RDATA_0 <= RAM_Q_R;
         end
         if (b_valid && !b_we && b_port) begin
            RDATA_1 <= RAM_Q_R;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM
`timescale 1ns/1ps
module tb_ram_arbiter;
   localparam int DW = 32;
   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          REQ_0, REQ_1, WE_0, WE_1;
   logic [AW-1:0] ADDR_0, ADDR_1;
   logic [DW-1:0] WDATA_0, WDATA_1;
   logic          GNT_0, GNT_1, RVALID_0, RVALID_1;
   logic [DW-1:0] RDATA_0, RDATA_1;
   logic          RAM_ENABLE_W;
   logic [AW-1:0] RAM_ADDR_W, RAM_ADDR_R;
   logic [DW-1:0] RAM_Q_W, RAM_Q_R;

   ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_0(REQ_0), .REQ_1(REQ_1), .WE_0(WE_0), .WE_1(WE_1),
      .ADDR_0(ADDR_0), .ADDR_1(ADDR_1), .WDATA_0(WDATA_0), .WDATA_1(WDATA_1),
      .GNT_0(GNT_0), .GNT_1(GNT_1), .RVALID_0(RVALID_0), .RVALID_1(RVALID_1),
      .RDATA_0(RDATA_0), .RDATA_1(RDATA_1),
      .RAM_ENABLE_W(RAM_ENABLE_W), .RAM_ADDR_W(RAM_ADDR_W), .RAM_Q_W(RAM_Q_W),
      .RAM_ADDR_R(RAM_ADDR_R), .RAM_Q_R(RAM_Q_R)
   );

   always #5 CLK = ~CLK;

   // behavioural RAM: synchronous write, combinational read
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge CLK) if (RAM_ENABLE_W) mem[RAM_ADDR_W] <= RAM_Q_W;
   assign RAM_Q_R = mem[RAM_ADDR_R];

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // reference model: memory contents in accept order plus arbitration state
   logic [DW-1:0] ref_mem [int];
   bit            ref_last = 1'b1;

   typedef struct { logic [DW-1:0] data; int due; } rd_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } wr_t;
   rd_t rq0[$];
   rd_t rq1[$];
   wr_t wq[$];

   task automatic model_accept(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rd_t r;
      ref_last = p;
      if (we) begin
         ref_mem[int'(a)] = d;
         wq.push_back('{a, d, cyc + 2});
      end else begin
         r.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
         r.due  = cyc + 2;
         if (p) rq1.push_back(r);
         else   rq0.push_back(r);
      end
   endtask

   // monitor: pops expected read returns / write commits as the DUT presents them
   always @(negedge CLK) begin
      rd_t r;
      wr_t w;
      if (!RESET) begin
         if (RVALID_0) begin
            if (rq0.size() == 0) chk("rvalid0_unexpected", 1, 0);
            else begin
               r = rq0.pop_front();
               chk("rdata0", RDATA_0, r.data);
               chk("rlat0", cyc, r.due);
            end
         end else if (rq0.size() != 0 && rq0[0].due <= cyc) begin
            chk("rvalid0_missing", 0, 1);
            void'(rq0.pop_front());
         end
         if (RVALID_1) begin
            if (rq1.size() == 0) chk("rvalid1_unexpected", 1, 0);
            else begin
               r = rq1.pop_front();
               chk("rdata1", RDATA_1, r.data);
               chk("rlat1", cyc, r.due);
            end
         end else if (rq1.size() != 0 && rq1[0].due <= cyc) begin
            chk("rvalid1_missing", 0, 1);
            void'(rq1.pop_front());
         end
         while (wq.size() != 0 && wq[0].due <= cyc) begin
            w = wq.pop_front();
            chk("write_commit", mem[w.addr], w.data);
         end
      end
   end

   // one cycle of stimulus, called just after a falling edge
   task automatic cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output bit ag0, output bit ag1);
      bit eg0, eg1;
      REQ_0 = r0; WE_0 = w0; ADDR_0 = a0; WDATA_0 = d0;
      REQ_1 = r1; WE_1 = w1; ADDR_1 = a1; WDATA_1 = d1;
      #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
      eg0 = r0;
      eg1 = r1 && !r0;
`else
      if (r0 && r1) begin
         eg0 = ref_last;
         eg1 = !ref_last;
      end else begin
         eg0 = r0;
         eg1 = r1;
      end
`endif
      chk("gnt0", GNT_0, eg0);
      chk("gnt1", GNT_1, eg1);
      chk("gnt_exclusive", GNT_0 && GNT_1, 0);
      chk("gnt_without_req", (GNT_0 && !REQ_0) || (GNT_1 && !REQ_1), 0);
      ag0 = GNT_0;
      ag1 = GNT_1;
      if (eg0) model_accept(1'b0, w0, a0, d0);
      if (eg1) model_accept(1'b1, w1, a1, d1);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      bit g0, g1;
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
   endtask

   typedef struct { bit v; bit we; logic [AW-1:0] a; logic [DW-1:0] d; } pend_t;

   initial begin
      bit g0, g1;
      pend_t p0, p1;
      RESET = 1'b1;
      REQ_0 = 1'b1; REQ_1 = 1'b1; WE_0 = 1'b0; WE_1 = 1'b0;
      ADDR_0 = '0; ADDR_1 = '0; WDATA_0 = '0; WDATA_1 = '0;
      @(posedge CLK); @(posedge CLK); @(negedge CLK);
      chk("rst_gnt0", GNT_0, 0);
      chk("rst_gnt1", GNT_1, 0);
      chk("rst_ram_en", RAM_ENABLE_W, 0);
      chk("rst_ram_addr_w", RAM_ADDR_W, 0);
      chk("rst_ram_addr_r", RAM_ADDR_R, 0);
      chk("rst_ram_q_w", RAM_Q_W, 0);
      chk("rst_rvalid", {RVALID_0, RVALID_1}, 0);
      chk("rst_rdata", {RDATA_0, RDATA_1}, 0);
      REQ_0 = 1'b0; REQ_1 = 1'b0;
      RESET = 1'b0;

      // single port write then read of the same word
      cycle(1, 1, 10'h005, 32'hDEADBEEF, 0, 0, '0, '0, g0, g1);
      cycle(1, 0, 10'h005, '0, 0, 0, '0, '0, g0, g1);
      idle(3);

      // preload contention addresses, then reset in the middle of a write
      cycle(1, 1, 10'h010, 32'hA0A0_0010, 0, 0, '0, '0, g0, g1);
      cycle(0, 0, '0, '0, 1, 1, 10'h020, 32'hB0B0_0020, g0, g1);
      cycle(1, 0, 10'h005, '0, 0, 0, '0, '0, g0, g1);
      idle(3);
      REQ_0 = 1'b1; WE_0 = 1'b1; ADDR_0 = 10'h005; WDATA_0 = 32'hBAD0_BAD0;
      #1 chk("pre_rst_gnt", GNT_0, 1);
      @(posedge CLK);
      #2 chk("pre_rst_ram_en", RAM_ENABLE_W, 1);
      RESET = 1'b1;
      #1;
      chk("async_rst_ram_en", RAM_ENABLE_W, 0);
      chk("async_rst_gnt", GNT_0, 0);
      chk("async_rst_rdata0", RDATA_0, 0);
      chk("async_rst_rvalid", {RVALID_0, RVALID_1}, 0);
      REQ_0 = 1'b0; WE_0 = 1'b0;
      @(posedge CLK); @(negedge CLK);
      chk("rst_write_discarded", mem[5], 32'hDEADBEEF);
      rq0.delete(); rq1.delete(); wq.delete();
      ref_last = 1'b1;
      RESET = 1'b0;

      // contention after reset: both read, grants alternate (fixed: port 0 always)
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 10'h010, '0, 1, 0, 10'h020, '0, g0, g1);
`ifdef RAM_ARB_FIXED_PRIO_EN
         chk("contend_gnt0", g0, 1);
         chk("contend_gnt1", g1, 0);
`else
         chk("contend_gnt0", g0, (i % 2 == 0) ? 1 : 0);
         chk("contend_gnt1", g1, (i % 2 == 0) ? 0 : 1);
`endif
      end
      // fixed priority leaves port 1 pending; let it through
      idle(1);
      cycle(0, 0, '0, '0, 1, 0, 10'h020, '0, g0, g1);
      idle(3);

      // cross-port read-after-write at the top address
      cycle(0, 0, '0, '0, 1, 1, 10'h3FF, 32'h12345678, g0, g1);
      cycle(1, 0, 10'h3FF, '0, 0, 0, '0, '0, g0, g1);
      idle(3);

      // streaming reads on port 1
      for (int i = 0; i < 8; i++) cycle(0, 0, '0, '0, 1, 1, AW'(i), DW'(32'h100 + i), g0, g1);
      for (int i = 0; i < 8; i++) cycle(0, 0, '0, '0, 1, 0, AW'(i), '0, g0, g1);
      idle(3);

      // randomized traffic; requests hold until granted
      p0.v = 0; p1.v = 0;
      for (int n = 0; n < 400; n++) begin
         if (!p0.v && $urandom_range(0, 3) != 0) begin
            p0.v = 1;
            p0.a = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
            p0.we = (!ref_mem.exists(int'(p0.a))) || ($urandom_range(0, 1) == 1);
            p0.d = $urandom;
         end
         if (!p1.v && $urandom_range(0, 3) != 0) begin
            p1.v = 1;
            p1.a = ($urandom_range(0, 9) == 0) ? 10'h000 : AW'($urandom_range(0, 15));
            p1.we = (!ref_mem.exists(int'(p1.a))) || ($urandom_range(0, 1) == 1);
            p1.d = $urandom;
         end
         cycle(p0.v, p0.we, p0.a, p0.d, p1.v, p1.we, p1.a, p1.d, g0, g1);
         if (g0) p0.v = 0;
         if (g1) p1.v = 0;
      end
      idle(4);
      chk("scoreboard_drained", rq0.size() + rq1.size() + wq.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-write-port / single-read-port data RAM between the core load/store unit (port 0) and the program loader/debug master (port 1). Each cycle it accepts at most one request with round-robin fairness. It registers the accepted command and drives the RAM from that register, so writes commit one cycle after acceptance. Read data is returned, registered, with a per-port valid pulse.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM word address width
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- REQ_0 / REQ_1  in  1  request valid, held until granted
- WE_0 / WE_1  in  1  1 = write, 0 = read
- ADDR_0 / ADDR_1  in  ADDR_WIDTH  word address
- WDATA_0 / WDATA_1  in  DATA_WIDTH  write data (ignored for reads)
- GNT_0 / GNT_1  out  1  combinational accept; transfer occurs on an edge with REQ_x && GNT_x
- RVALID_0 / RVALID_1  out  1  registered one-cycle read-data valid
- RDATA_0 / RDATA_1  out  DATA_WIDTH  registered read data, held until the next read return to that port
- RAM_ENABLE_W  out  1  to RAM write enable
- RAM_ADDR_W  out  ADDR_WIDTH  to RAM write address
- RAM_Q_W  out  DATA_WIDTH  to RAM write data
- RAM_ADDR_R  out  ADDR_WIDTH  to RAM read address
- RAM_Q_R  in  DATA_WIDTH  combinational RAM read data

## Operation
- Two pipeline stages:
  - A (accept): arbitration and GNT.
  - B (access): latched command drives RAM.
  - RVALID/RDATA registered after B.
- Stage A is never stalled, so one request is accepted every cycle when any REQ is high.
- Arbitration:
  - Only one of REQ_0/REQ_1 high: that port is granted.
  - Both high: grant the port not equal to LAST.
  - LAST register updates to the granted port on every accept.
  - GNT_0 and GNT_1 are never high together.
  - A GNT is never high without its REQ.
- Accept edge: latch B_VALID=1, B_PORT, B_WE, B_ADDR, B_WDATA. With no accept, B_VALID=0 and the other B fields are held.
- Stage B outputs:
  - RAM_ENABLE_W = B_VALID && B_WE.
  - RAM_ADDR_W = RAM_ADDR_R = B_ADDR.
  - RAM_Q_W = B_WDATA.
- Stage B read (B_VALID && !B_WE): at the next edge, RDATA_<B_PORT> <= RAM_Q_R and RVALID_<B_PORT> <= 1. The other port's RVALID is 0.
- RVALID_x is 0 in every cycle not following a stage-B read for port x.
- Address arithmetic: none. Addresses pass unmodified; full ADDR_WIDTH range, no wrap handling.
- Read-after-write to the same address, accepted on consecutive edges: the write commits at the same edge the read enters B, so the read returns the new data. No forwarding is needed.
- Reset (asynchronous, any time):
  - B_VALID=0, so RAM_ENABLE_W drops immediately and an in-flight write is discarded.
  - An in-flight read produces no RVALID.
  - LAST=1, so port 0 wins the first contention.
  - RVALID_0/1=0, RDATA_0/1=0, B_ADDR=0, B_WDATA=0, B_WE=0, B_PORT=0.
  - GNT_x is forced 0 while RESET is high.

## Timing
- Accept at edge E0 (REQ_x && GNT_x).
- Write: RAM_ENABLE_W high for exactly the cycle E0..E1; data is in RAM after E1.
- Read: RAM addressed during E0..E1; RVALID_x high during E1..E2. Read latency is 2 edges from acceptance.
- Back-to-back accepts produce back-to-back RVALID pulses (throughput 1/cycle).
- GNT depends combinationally on REQ_0/REQ_1, LAST, and RESET only, not on WE/ADDR.
- Reset values:
  - GNT=0.
  - RVALID=0, RDATA=0.
  - RAM_ENABLE_W=0, RAM_ADDR_W=0, RAM_ADDR_R=0, RAM_Q_W=0.

## Configuration
- RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins contention. The LAST register is not implemented, and port 1 is granted only when REQ_0=0.
- Not defined: round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset: RESET=1 mid-write (B_VALID=1, WE=1) → RAM_ENABLE_W falls without a clock edge; the RAM word is unchanged; RVALID_0/1=0, RDATA=0.
- Single port: port 0 writes 0xDEADBEEF to address 0x005, then reads 0x005 on the next edge → RVALID_0 high 2 edges after the read accept with RDATA_0=0xDEADBEEF. RVALID_1 stays 0.
- Contention after reset: REQ_0 and REQ_1 held high, both reads, addresses 0x010/0x020 → grants alternate 0,1,0,1 each cycle (round-robin). With RAM_ARB_FIXED_PRIO_EN, port 0 is granted every cycle and GNT_1 stays 0.
- Cross-port read-after-write: port 1 writes 0x12345678 to address 0x3FF; the following cycle port 0 reads 0x3FF → RDATA_0=0x12345678.
- Streaming: port 1 issues 8 consecutive reads (addresses 0..7, preloaded with value=addr+0x100) → 8 consecutive RVALID_1 cycles with RDATA_1=0x100..0x107 in order.
- Invariant checks: GNT_0 && GNT_1 never true; GNT_x never high without REQ_x; every write accept is followed by the RAM holding WDATA one edge later.
